// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational ALU: operations are queued in a FIFO,
// presented to the ALU for ALU_LAT cycles, and their results are held until accepted.
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [3:0]               in_opcode,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [3:0]               alu_opcode,
    input  logic [3:0]               alu_x,
    input  logic [3:0]               alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_x,
    output logic [3:0]               out_y,
    output logic [3:0]               out_opcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [AW-1:0] P_ONE    = AW'(1);
    localparam logic [LW-1:0] L_ONE    = LW'(1);
    localparam logic [LW-1:0] L_LAST   = LW'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t          r_state;
    logic [11:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic [LW-1:0]   r_latCnt;
    logic [3:0]      r_aluA;
    logic [3:0]      r_aluB;
    logic [3:0]      r_aluOp;
    logic            r_outValid;
    logic [3:0]      r_outX;
    logic [3:0]      r_outY;
    logic [3:0]      r_outOp;

    logic            w_inReady;
    logic            w_push;
    logic            w_notEmpty;
    logic            w_load;
    logic            w_capture;
    logic [11:0]     w_head;

    // Readiness comes only from the registered count, so a pop cannot make room the same cycle.
    assign w_inReady  = (r_count < C_FULL);
    assign w_push     = in_valid && w_inReady;
    assign w_notEmpty = (r_count != '0);
    assign w_load     = w_notEmpty && ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
    assign w_capture  = (r_state == WAIT) && (r_latCnt == L_LAST);
    assign w_head     = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {in_a, in_b, in_opcode};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_latCnt   <= '0;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluOp    <= '0;
            r_outValid <= 1'b0;
            r_outX     <= '0;
            r_outY     <= '0;
            r_outOp    <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + P_ONE;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase

            // A load pops the head and restarts the latency count, from IDLE or an accepted HOLD.
            if (w_load) begin
                r_aluA   <= w_head[11:8];
                r_aluB   <= w_head[7:4];
                r_aluOp  <= w_head[3:0];
                r_rdPtr  <= r_rdPtr + P_ONE;
                r_latCnt <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_capture) begin
                        r_outX     <= alu_x;
                        r_outY     <= alu_y;
                        r_outOp    <= r_aluOp;
                        r_outValid <= 1'b1;
                        r_state    <= HOLD;
                    end else begin
                        r_latCnt <= r_latCnt + L_ONE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= w_load ? WAIT : IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_inReady;
    assign count      = r_count;
    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign alu_opcode = r_aluOp;
    assign out_valid  = r_outValid;
    assign out_x      = r_outX;
    assign out_y      = r_outY;
    assign out_opcode = r_outOp;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model; a second instance uses ALU_LAT=3.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_a, in_b, in_opcode;
    logic [3:0] alu_a, alu_b, alu_opcode, alu_x, alu_y;
    logic [3:0] out_x, out_y, out_opcode;
    logic [$clog2(DEPTH):0] count;

    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [3:0] in_a2, in_b2, in_opcode2;
    logic [3:0] alu_a2, alu_b2, alu_opcode2, alu_x2, alu_y2;
    logic [3:0] out_x2, out_y2, out_opcode2;
    logic [$clog2(DEPTH):0] count2;

    int numCompared;
    int numMismatched;
    bit chkEn;

    alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_x(alu_x), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_opcode(out_opcode),
        .count(count)
    );

    alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_opcode(in_opcode2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2),
        .alu_x(alu_x2), .alu_y(alu_y2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_x(out_x2), .out_y(out_y2), .out_opcode(out_opcode2),
        .count(count2)
    );

    // The ALU under the queue: x is the XOR of the operands, y echoes the opcode.
    assign alu_x  = alu_a ^ alu_b;
    assign alu_y  = alu_opcode;
    assign alu_x2 = alu_a2 ^ alu_b2;
    assign alu_y2 = alu_opcode2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: queued operations, one op being computed for LAT cycles, then a held result.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } opT;

    opT         mq[$];
    opT         cur;
    opT         nw;
    int         stage;
    int         remain;
    bit         doPush;
    bit         take;
    logic       mValid;
    logic [3:0] mX, mY, mOp, mAluA, mAluB, mAluOp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            stage  = 0;
            remain = 0;
            mValid = 1'b0;
            mX = 4'h0; mY = 4'h0; mOp = 4'h0;
            mAluA = 4'h0; mAluB = 4'h0; mAluOp = 4'h0;
        end else begin
            doPush = in_valid && (mq.size() < DEPTH);
            nw     = '{a: in_a, b: in_b, op: in_opcode};
            take   = 1'b0;
            if (stage == 0) begin
                take = (mq.size() > 0);
            end else if (stage == 1) begin
                remain--;
                if (remain == 0) begin
                    mValid = 1'b1;
                    mX     = cur.a ^ cur.b;
                    mY     = cur.op;
                    mOp    = cur.op;
                    stage  = 2;
                end
            end else if (out_ready) begin
                mValid = 1'b0;
                take   = (mq.size() > 0);
                if (!take) stage = 0;
            end
            if (take) begin
                cur    = mq.pop_front();
                mAluA  = cur.a;
                mAluB  = cur.b;
                mAluOp = cur.op;
                stage  = 1;
                remain = LAT;
            end
            if (doPush) mq.push_back(nw);
        end
    end

    always @(negedge clk) begin
        if (chkEn && rst_n) begin
            checkOutput("in_ready",   8'(in_ready),   8'(mq.size() < DEPTH));
            checkOutput("count",      8'(count),      8'(mq.size()));
            checkOutput("out_valid",  8'(out_valid),  8'(mValid));
            checkOutput("alu_a",      8'(alu_a),      8'(mAluA));
            checkOutput("alu_b",      8'(alu_b),      8'(mAluB));
            checkOutput("alu_opcode", 8'(alu_opcode), 8'(mAluOp));
            if (mValid) begin
                checkOutput("out_x",      8'(out_x),      8'(mX));
                checkOutput("out_y",      8'(out_y),      8'(mY));
                checkOutput("out_opcode", 8'(out_opcode), 8'(mOp));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic r);
        in_valid  = v;
        out_ready = r;
        in_a      = 4'($urandom_range(0, 15));
        in_b      = 4'($urandom_range(0, 15));
        in_opcode = 4'($urandom_range(0, 15));
    endtask

    task automatic singleOp(input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_a = 4'b1100; in_b = 4'b0010; in_opcode = 4'b1010; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_count"}, 8'(count), 8'd1);
        @(negedge clk);
        checkOutput({tag, "_alu_a"}, 8'(alu_a), 8'hC);
        checkOutput({tag, "_early_valid"}, 8'(out_valid), 8'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 8'(out_valid), 8'd1);
        checkOutput({tag, "_x"}, 8'(out_x), 8'hE);
        checkOutput({tag, "_y"}, 8'(out_y), 8'hA);
        checkOutput({tag, "_op"}, 8'(out_opcode), 8'hA);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_done"}, 8'(out_valid), 8'd0);
        out_ready = 1'b0;
    endtask

    int pv[4] = '{80, 30, 90, 60};
    int pr[4] = '{30, 90, 90, 50};

    initial begin
        numCompared = 0; numMismatched = 0; chkEn = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_opcode = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_a2 = '0; in_b2 = '0; in_opcode2 = '0;
        #3;
        checkOutput("rst_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_ready", 8'(in_ready), 8'd1);
        checkOutput("rst_count", 8'(count), 8'd0);
        checkOutput("rst_alu_a", 8'(alu_a), 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chkEn = 1'b1;

        singleOp("single");

        // Fill with the result held, then pop at full with a push offered.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0);
        end
        @(negedge clk);
        checkOutput("fill_count", 8'(count), 8'd4);
        checkOutput("fill_ready", 8'(in_ready), 8'd0);
        checkOutput("fill_valid", 8'(out_valid), 8'd1);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("fullpop_count", 8'(count), 8'd3);
        checkOutput("fullpop_ready", 8'(in_ready), 8'd1);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_push", 8'(count), 8'd4);
        applyStimulus(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("drain_count", 8'(count), 8'd0);
        checkOutput("drain_valid", 8'(out_valid), 8'd0);

        // Reset while an operation is in flight with three more queued.
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midop_count", 8'(count), 8'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 8'(out_valid), 8'd0);
        checkOutput("midrst_count", 8'(count), 8'd0);
        checkOutput("midrst_ready", 8'(in_ready), 8'd1);
        checkOutput("midrst_alu", 8'({alu_a, alu_b} | {alu_opcode, out_x}), 8'd0);
        checkOutput("midrst_out", 8'({out_y, out_opcode}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        singleOp("after_rst");

        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                applyStimulus(1'($urandom_range(0, 99) < pv[s]), 1'($urandom_range(0, 99) < pr[s]));
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("final_count", 8'(count), 8'd0);

        // Longer ALU latency: operands held four edges, result visible after the fourth.
        @(negedge clk);
        in_valid2 = 1'b1; in_a2 = 4'h9; in_b2 = 4'h3; in_opcode2 = 4'h6; out_ready2 = 1'b0;
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("lat3_valid", 8'(out_valid2), 8'(k == 4));
            checkOutput("lat3_alu_a", 8'(alu_a2), 8'h9);
            checkOutput("lat3_alu_b", 8'(alu_b2), 8'h3);
            checkOutput("lat3_alu_op", 8'(alu_opcode2), 8'h6);
        end
        checkOutput("lat3_x", 8'(out_x2), 8'hA);
        checkOutput("lat3_y", 8'(out_y2), 8'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operation FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ALU_LAT, default 1, meaning cycles operands are held stable before alu_x/alu_y are sampled (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-006 SHALL have ports in_a, in_b, in_opcode, each input 4, the operation to enqueue.
REQ-007 SHALL have ports alu_a, alu_b, alu_opcode, each output 4, registered operands driven to the combinational ALU.
REQ-008 SHALL have ports alu_x, alu_y, each input 4, the ALU results.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-010 SHALL have ports out_x, out_y, out_opcode, each output 4, the captured results and their opcode tag.
REQ-011 SHALL have port count  output  clog2(DEPTH)+1  FIFO occupancy, excluding the in-flight operation.

Function
REQ-012 SHALL accept a push on a rising edge with in_valid && in_ready, and write {in_a,in_b,in_opcode} at the FIFO tail.
REQ-013 SHALL drive in_ready = (count < DEPTH), depending only on registered state; a same-cycle pop SHALL NOT free space for a push into a full FIFO.
REQ-014 SHALL have no bypass path; every operation passes through the FIFO, even when the FIFO is empty.
REQ-015 SHALL implement FSM states IDLE, WAIT and HOLD.
REQ-016 IDLE: on an edge with count>0, SHALL load the FIFO head into alu_a/alu_b/alu_opcode, pop it, clear the latency counter, and go to WAIT.
REQ-017 WAIT: SHALL hold the operands and increment the counter each cycle.
REQ-018 WAIT: on the ALU_LAT-th edge after the load, SHALL register alu_x->out_x, alu_y->out_y, alu_opcode->out_opcode, set out_valid=1, and go to HOLD.
REQ-019 HOLD: SHALL keep out_valid=1 and out_x/out_y/out_opcode stable until an edge with out_ready=1.
REQ-020 HOLD: on the out_ready=1 edge, if count>0 SHALL clear out_valid and load and pop the next entry in that edge (-> WAIT); else SHALL clear out_valid and go to IDLE.
REQ-021 Latency: for a push accepted at edge E into an empty, idle queue, the operand load SHALL occur at E+1 and out_valid SHALL rise at E+1+ALU_LAT.
REQ-022 Throughput: with out_ready held 1, one result SHALL be produced every ALU_LAT+1 cycles.
REQ-023 Results SHALL leave in strict FIFO order.
REQ-024 On an edge with a simultaneous push and pop, count SHALL be unchanged and both operations SHALL take effect.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 alu_a/alu_b/alu_opcode SHALL retain their last values after capture; they are not cleared.
REQ-027 out_valid SHALL be 0 outside HOLD.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock: clear all outputs to 0, set in_ready=1 and count=0, set FSM=IDLE, zero the pointers and latency counter, and discard in-flight and queued operations.
REQ-029 On the first edge after rst_n deasserts, SHALL accept pushes normally.

Verification
Benches SHALL model the ALU as alu_x = alu_a ^ alu_b and alu_y = alu_opcode. ALU_LAT=1 unless stated.
REQ-030 Single op: push a=1100 b=0010 op=1010 at edge E -> alu_a=1100 after E+1; out_valid=1 after E+2 with out_x=1110, out_y=1010, out_opcode=1010.
REQ-031 Fill: out_ready=0, push every cycle from E -> 5 pushes accepted (E..E+4); then in_ready=0, count=4; out_valid stays 1 with out_x stable.
REQ-032 Drain: from the REQ-031 state, raise out_ready=1 -> 5 results in push order, out_valid pulses spaced 2 cycles apart, in_ready=1 after the first pop.
REQ-033 Full with simultaneous pop: count=4, out_ready=1, in_valid=1 -> no push on the popping edge; push accepted on the next edge.
REQ-034 Reset mid-op: rst_n=0 while in WAIT with count=3 -> all outputs 0 at once, count=0; a new push completes per REQ-030 timing.
REQ-035 ALU_LAT=3: a single push at E -> out_valid rises at E+4, and operands stay constant over E+1..E+4.
